// File: rtl/phase_controller.sv
// Multi-cycle instruction sequencer: walks IF/ID/EX/MEM/WB, handshakes with the
// shared memory port and gates decoder write classes into single-cycle strobes.
module phase_controller #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        run,
  input  logic        halt_cmd,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        reg_wr,
  input  logic        pc_ld,
  input  logic        sp_inc,
  input  logic        sp_dec,
  input  logic        out_req,
  input  logic        branch_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        reg_we,
  output logic        pc_load_en,
  output logic        sp_inc_en,
  output logic        sp_dec_en,
  output logic        out_en,
  output logic [2:0]  phase,
  output logic        halted,
  output logic        fault,
  output logic [15:0] icount
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       wait_last;
  logic       c_rd;
  logic       c_wr;
  logic       c_reg;
  logic       c_pc;
  logic       c_inc;
  logic       c_dec;
  logic       c_out;

  assign waiting   = (state == S_IF) || (state == S_MEM);
  assign wait_last = (wait_cnt == WAIT_LAST);

  // An ack on the last allowed cycle wins over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (run) state_nxt = S_IF;
      S_IF: begin
        if (mem_ack)        state_nxt = S_ID;
        else if (wait_last) state_nxt = S_HALT;
      end
      S_ID:  state_nxt = halt_cmd ? S_HALT : S_EX;
      S_EX:  state_nxt = (c_rd || c_wr) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ack)        state_nxt = S_WB;
        else if (wait_last) state_nxt = S_HALT;
      end
      S_WB:   state_nxt = run ? S_IF : S_IDLE;
      S_HALT: if (!run) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
      wait_cnt <= 8'd0;
      icount   <= 16'd0;
      c_rd     <= 1'b0;
      c_wr     <= 1'b0;
      c_reg    <= 1'b0;
      c_pc     <= 1'b0;
      c_inc    <= 1'b0;
      c_dec    <= 1'b0;
      c_out    <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_req <= (state_nxt == S_IF) || (state_nxt == S_MEM);
      mem_we  <= (state_nxt == S_MEM) && c_wr;
      halted  <= (state_nxt == S_HALT);

      if (waiting && !mem_ack) wait_cnt <= wait_cnt + 8'd1;
      else                     wait_cnt <= 8'd0;

      if (waiting && !mem_ack && wait_last) fault <= 1'b1;

      if (state == S_WB) icount <= icount + 16'd1;

      if (state == S_ID && !halt_cmd) begin
        c_rd  <= mem_rd;
        c_wr  <= mem_wr;
        c_reg <= reg_wr;
        c_pc  <= pc_ld;
        c_inc <= sp_inc;
        c_dec <= sp_dec;
        c_out <= out_req;
      end
    end
  end

  assign phase      = state;
  assign ir_load    = (state == S_IF) && mem_ack;
  assign pc_inc     = (state == S_IF) && mem_ack;
  assign reg_we     = (state == S_WB) && c_reg;
  assign pc_load_en = (state == S_WB) && c_pc && branch_taken;
  assign sp_inc_en  = (state == S_WB) && c_inc;
  assign sp_dec_en  = (state == S_WB) && c_dec;
  assign out_en     = (state == S_EX) && c_out;

endmodule

// File: tb/tb_phase_controller.sv
// Bench for phase_controller: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a phase-level model.
`timescale 1ns/1ps
module tb_phase_controller;

  localparam int ACK_T = 4;
  localparam int P_IDLE = 0, P_IF = 1, P_ID = 2, P_EX = 3, P_MEM = 4, P_WB = 5, P_HALT = 6;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic run = 0, halt_cmd = 0, mem_rd = 0, mem_wr = 0, reg_wr = 0, pc_ld = 0;
  logic sp_inc = 0, sp_dec = 0, out_req = 0, branch_taken = 0, mem_ack = 0;
  logic mem_req, mem_we, ir_load, pc_inc, reg_we, pc_load_en, sp_inc_en, sp_dec_en, out_en;
  logic [2:0] phase;
  logic halted, fault;
  logic [15:0] icount;

  int tests = 0;
  int fails = 0;

  // Model state: current phase, unacked cycles so far, sticky fault, count, latched classes.
  int m_ph = P_IDLE;
  int m_wait = 0;
  bit m_fault = 0;
  bit [15:0] m_icount = 0;
  bit m_rd = 0, m_wr = 0, m_reg = 0, m_pc = 0, m_inc = 0, m_dec = 0, m_out = 0;

  phase_controller #(.ACK_TIMEOUT(ACK_T)) dut (
    .clk(clk), .n_rst(n_rst), .run(run), .halt_cmd(halt_cmd),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr), .pc_ld(pc_ld),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .out_req(out_req),
    .branch_taken(branch_taken), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .pc_inc(pc_inc),
    .reg_we(reg_we), .pc_load_en(pc_load_en), .sp_inc_en(sp_inc_en),
    .sp_dec_en(sp_dec_en), .out_en(out_en), .phase(phase),
    .halted(halted), .fault(fault), .icount(icount)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model advancing one phase per clock from the sequencing rules.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_ph = P_IDLE; m_wait = 0; m_fault = 0; m_icount = 0;
      {m_rd, m_wr, m_reg, m_pc, m_inc, m_dec, m_out} = '0;
    end else begin
      case (m_ph)
        P_IDLE: if (run) begin m_ph = P_IF; m_wait = 0; end
        P_IF, P_MEM: begin
          if (mem_ack) m_ph = (m_ph == P_IF) ? P_ID : P_WB;
          else if (m_wait + 1 == ACK_T) begin m_ph = P_HALT; m_fault = 1; end
          else m_wait++;
        end
        P_ID: begin
          if (halt_cmd) m_ph = P_HALT;
          else begin
            {m_rd, m_wr, m_reg, m_pc, m_inc, m_dec, m_out} =
              {mem_rd, mem_wr, reg_wr, pc_ld, sp_inc, sp_dec, out_req};
            m_ph = P_EX;
          end
        end
        P_EX: begin m_ph = (m_rd || m_wr) ? P_MEM : P_WB; m_wait = 0; end
        P_WB: begin m_icount++; m_ph = run ? P_IF : P_IDLE; m_wait = 0; end
        default: if (!run) m_ph = P_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    #2;
    check_output("phase", int'(phase), m_ph);
    check_output("mem_req", int'(mem_req), int'(m_ph == P_IF || m_ph == P_MEM));
    check_output("mem_we", int'(mem_we), int'(m_ph == P_MEM && m_wr));
    check_output("ir_load", int'(ir_load), int'(m_ph == P_IF && mem_ack));
    check_output("pc_inc", int'(pc_inc), int'(m_ph == P_IF && mem_ack));
    check_output("reg_we", int'(reg_we), int'(m_ph == P_WB && m_reg));
    check_output("pc_load_en", int'(pc_load_en), int'(m_ph == P_WB && m_pc && branch_taken));
    check_output("sp_inc_en", int'(sp_inc_en), int'(m_ph == P_WB && m_inc));
    check_output("sp_dec_en", int'(sp_dec_en), int'(m_ph == P_WB && m_dec));
    check_output("out_en", int'(out_en), int'(m_ph == P_EX && m_out));
    check_output("halted", int'(halted), int'(m_ph == P_HALT));
    check_output("fault", int'(fault), int'(m_fault));
    check_output("icount", int'(icount), int'(m_icount));
  end

  task automatic clear_classes();
    {halt_cmd, mem_rd, mem_wr, reg_wr, pc_ld, sp_inc, sp_dec, out_req, branch_taken} = '0;
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n = 0;
    do begin @(negedge clk); #3; n++; end while (int'(phase) != p && n < budget);
    check_output("wait_phase", int'(phase), p);
  endtask

  task automatic apply_stimulus();
    @(negedge clk);
    run          = ($urandom_range(0, 99) < 85);
    halt_cmd     = ($urandom_range(0, 99) < 8);
    mem_rd       = 1'($urandom);
    mem_wr       = ($urandom_range(0, 99) < 30);
    reg_wr       = 1'($urandom);
    pc_ld        = 1'($urandom);
    sp_inc       = 1'($urandom);
    sp_dec       = 1'($urandom);
    out_req      = 1'($urandom);
    branch_taken = 1'($urandom);
    mem_ack      = ($urandom_range(0, 99) < 65);
  endtask

  initial begin
    int cnt_a, cnt_b, cnt_c;
    logic [2:0] seq1 [6];
    logic [2:0] seq2 [10];
    logic       ack2 [10];
    seq1 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    seq2 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0};
    ack2 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    #1 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check_output("rst_mem_req", int'(mem_req), 0);
    check_output("rst_icount", int'(icount), 0);
    check_output("rst_fault", int'(fault), 0);

    // ALU instruction with ack tied high.
    @(negedge clk);
    n_rst = 1'b1; run = 1; reg_wr = 1; mem_ack = 1;
    cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #3;
      check_output("alu_seq", int'(phase), int'(seq1[i]));
      cnt_a += int'(reg_we);
    end
    check_output("alu_reg_we_pulses", cnt_a, 1);
    check_output("alu_icount", int'(icount), 1);
    @(negedge clk); run = 0;
    wait_phase(P_IDLE, 20);
    check_output("alu2_icount", int'(icount), 2);

    // Load with three unacked MEM cycles; run dropped mid-instruction.
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin clear_classes(); run = 1; reg_wr = 1; mem_rd = 1; end
      if (k == 1) run = 0;
      mem_ack = ack2[k];
      #3;
      check_output("load_seq", int'(phase), int'(seq2[k]));
      if (k >= 1 && k <= 8) cnt_a += int'(mem_req);
      cnt_b += int'(mem_we);
      if (k == 8) cnt_c = int'(reg_we);
    end
    check_output("load_mem_req_cycles", cnt_a, 5);
    check_output("load_mem_we", cnt_b, 0);
    check_output("load_reg_we_wb", cnt_c, 1);
    check_output("load_icount", int'(icount), 3);

    // Two branches: not taken, then taken.
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin clear_classes(); run = 1; pc_ld = 1; mem_ack = 1; end
      if (k == 5) begin run = 0; branch_taken = 1; end
      #3;
      if (k >= 1 && k <= 4) cnt_a += int'(pc_load_en);
      if (k >= 5) cnt_b += int'(pc_load_en);
      cnt_c += int'(pc_inc);
    end
    check_output("br_not_taken", cnt_a, 0);
    check_output("br_taken", cnt_b, 1);
    check_output("br_pc_inc", cnt_c, 2);
    check_output("br_idle", int'(phase), P_IDLE);
    check_output("br_icount", int'(icount), 5);

    // Fetch acked on the last allowed cycle.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin clear_classes(); run = 1; end
      if (k == 1) run = 0;
      mem_ack = (k == 4);
      #3;
      if (k == 4) begin
        check_output("late_ack_phase", int'(phase), P_IF);
        check_output("late_ack_ir_load", int'(ir_load), 1);
      end
      if (k == 5) begin
        check_output("late_ack_to_id", int'(phase), P_ID);
        check_output("late_ack_fault", int'(fault), 0);
      end
    end
    mem_ack = 1;
    wait_phase(P_IDLE, 20);

    // HLT in decode.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) begin clear_classes(); run = 1; halt_cmd = 1; mem_ack = 1; end
      if (k == 4) begin run = 0; halt_cmd = 0; end
      if (k == 5) run = 1;
      if (k == 6) run = 0;
      #3;
      if (k == 3) check_output("halt_halted", int'(halted), 1);
      if (k == 4) begin
        check_output("halt_hold", int'(phase), P_HALT);
        check_output("halt_icount", int'(icount), 6);
      end
      if (k == 5) check_output("halt_to_idle", int'(phase), P_IDLE);
      if (k == 6) check_output("halt_restart", int'(phase), P_IF);
    end
    wait_phase(P_IDLE, 20);

    // Fetch timeout.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) begin clear_classes(); run = 1; mem_ack = 0; end
      if (k == 5) run = 0;
      #3;
      if (k == 4) check_output("to_still_if", int'(phase), P_IF);
      if (k == 5) begin
        check_output("to_halt", int'(phase), P_HALT);
        check_output("to_fault", int'(fault), 1);
      end
      if (k == 6) begin
        check_output("to_idle", int'(phase), P_IDLE);
        check_output("to_fault_sticky", int'(fault), 1);
      end
    end

    // Async reset while a write request is outstanding.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin clear_classes(); run = 1; mem_rd = 1; mem_wr = 1; mem_ack = 1; end
      if (k == 4) mem_ack = 0;
      #3;
    end
    check_output("mid_mem_req", int'(mem_req), 1);
    check_output("mid_mem_we", int'(mem_we), 1);
    n_rst = 1'b0;
    #1;
    check_output("async_mem_req", int'(mem_req), 0);
    check_output("async_phase", int'(phase), P_IDLE);
    check_output("async_icount", int'(icount), 0);
    check_output("async_fault", int'(fault), 0);
    @(negedge clk);
    n_rst = 1'b1; run = 0; clear_classes(); mem_ack = 1;

    // Instruction counter wrap.
    @(negedge clk);
    force dut.icount = 16'hFFFE;
    m_icount = 16'hFFFE;
    #1 release dut.icount;
    run = 1;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (k == 5) run = 0;
      #3;
      if (k == 5) check_output("wrap_ffff", int'(icount), 16'hFFFF);
      if (k == 9) check_output("wrap_zero", int'(icount), 0);
    end

    repeat (3000) apply_stimulus();

    @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
